// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: F register (predicted PC), PC select with mispredict/ret
// recovery, request/ready handshake with instruction memory, and the field
// split feeding the decode pipeline register.
// Optional build macro FETCH_PERF_CNT_EN adds instruction/wait-cycle counters.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        F_stall_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [79:0] imem_data_i,
    input  logic        imem_err_i,
    output logic [3:0]  f_icode_o,
    output logic [3:0]  f_ifun_o,
    output logic [3:0]  f_rA_o,
    output logic [3:0]  f_rB_o,
    output logic [63:0] f_valC_o,
    output logic [63:0] f_valP_o,
    output logic [3:0]  f_stat_o,
    output logic        f_wait_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_inst_o,
    output logic [31:0] perf_wait_o,
`endif
    output logic [63:0] f_pc_o
);

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;
    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_q;
    logic [63:0] pred_pc_q;
    logic [63:0] addr_q;
    logic [79:0] buf_data_q;
    logic        buf_err_q;
    logic [63:0] buf_pc_q;

    logic [63:0] sel_pc;
    logic [63:0] cur_pc;
    logic [79:0] cur_data;
    logic        cur_err;

    logic [3:0]  dec_icode, dec_ifun, dec_ra, dec_rb, dec_stat;
    logic [63:0] dec_valc, dec_valp, dec_pred;
    logic        need_regids, need_valc;
    logic        accept;

    // PC select: jXX mispredict beats ret, which beats the prediction
    always_comb begin
        sel_pc = pred_pc_q;
        if (M_icode_i == IJXX && !M_cnd_i)
            sel_pc = M_valA_i;
        else if (W_icode_i == IRET)
            sel_pc = W_valM_i;
    end

    // Source of the instruction being presented: buffer in HOLD, memory otherwise
    always_comb begin
        cur_pc   = sel_pc;
        cur_data = imem_data_i;
        cur_err  = imem_err_i;
        case (state_q)
            ST_WAIT: cur_pc = addr_q;
            ST_HOLD: begin
                cur_pc   = buf_pc_q;
                cur_data = buf_data_q;
                cur_err  = buf_err_q;
            end
            default: ;
        endcase
    end

    // Field split, length, predicted next PC and status
    always_comb begin
        dec_icode   = cur_err ? INOP : cur_data[7:4];
        dec_ifun    = cur_err ? 4'h0 : cur_data[3:0];
        need_regids = dec_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        need_valc   = dec_icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        dec_ra      = need_regids ? cur_data[15:12] : RNONE;
        dec_rb      = need_regids ? cur_data[11:8]  : RNONE;
        dec_valc    = 64'h0;
        if (need_valc)
            dec_valc = need_regids ? cur_data[79:16] : cur_data[71:8];
        dec_valp    = cur_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);
        dec_pred    = (dec_icode == IJXX || dec_icode == ICALL) ? dec_valc : dec_valp;
        if (cur_err)
            dec_stat = SADR;
        else if (cur_data[7:4] > 4'hB)
            dec_stat = SINS;
        else if (dec_icode == IHALT)
            dec_stat = SHLT;
        else
            dec_stat = SAOK;
    end

    // Reset drops the request combinationally, even mid-WAIT
    assign imem_req_o  = rstn_i && (state_q != ST_HOLD);
    assign imem_addr_o = (state_q == ST_FETCH) ? sel_pc : addr_q;
    assign f_wait_o    = imem_req_o && !imem_ready_i;
    assign accept      = !F_stall_i && ((imem_req_o && imem_ready_i) || state_q == ST_HOLD);
    assign f_pc_o      = cur_pc;

    // Present a bubble while the fetch is outstanding
    always_comb begin
        f_icode_o = dec_icode;
        f_ifun_o  = dec_ifun;
        f_rA_o    = dec_ra;
        f_rB_o    = dec_rb;
        f_valC_o  = dec_valc;
        f_valP_o  = dec_valp;
        f_stat_o  = dec_stat;
        if (f_wait_o) begin
            f_icode_o = INOP;
            f_ifun_o  = 4'h0;
            f_rA_o    = RNONE;
            f_rB_o    = RNONE;
            f_valC_o  = 64'h0;
            f_valP_o  = 64'h0;
            f_stat_o  = SAOK;
        end
    end

    // Fetch FSM, F register and stall buffer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_FETCH;
            pred_pc_q  <= RESET_PC;
            addr_q     <= 64'h0;
            buf_data_q <= 80'h0;
            buf_err_q  <= 1'b0;
            buf_pc_q   <= 64'h0;
        end else begin
            case (state_q)
                ST_FETCH, ST_WAIT: begin
                    if (state_q == ST_FETCH)
                        addr_q <= sel_pc;
                    if (imem_ready_i) begin
                        if (!F_stall_i) begin
                            pred_pc_q <= dec_pred;
                            state_q   <= ST_FETCH;
                        end else begin
                            buf_data_q <= imem_data_i;
                            buf_err_q  <= imem_err_i;
                            buf_pc_q   <= cur_pc;
                            state_q    <= ST_HOLD;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!F_stall_i) begin
                        pred_pc_q <= dec_pred;
                        state_q   <= ST_FETCH;
                    end
                end
                default: state_q <= ST_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_inst_q, perf_wait_q;

    // Accepted-instruction and wait-cycle counters, free-running modulo 2^32
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_inst_q <= 32'h0;
            perf_wait_q <= 32'h0;
        end else begin
            if (accept)
                perf_inst_q <= perf_inst_q + 32'd1;
            if (f_wait_o)
                perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_inst_o = perf_inst_q;
    assign perf_wait_o = perf_wait_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed sequences, a vector table and a randomized
// run against a transaction-level fetch model backed by a hashed memory.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        F_stall_i;
    logic [3:0]  M_icode_i;
    logic        M_cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ready_i;
    logic [79:0] imem_data_i;
    logic        imem_err_i;
    logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_stat_o;
    logic [63:0] f_valC_o, f_valP_o, f_pc_o;
    logic        f_wait_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_inst, perf_wait;
`endif

    logic        use_mem;
    logic [79:0] drv_data;
    logic        drv_err;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .F_stall_i(F_stall_i),
        .M_icode_i(M_icode_i), .M_cnd_i(M_cnd_i), .M_valA_i(M_valA_i),
        .W_icode_i(W_icode_i), .W_valM_i(W_valM_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i), .imem_err_i(imem_err_i),
        .f_icode_o(f_icode_o), .f_ifun_o(f_ifun_o), .f_rA_o(f_rA_o), .f_rB_o(f_rB_o),
        .f_valC_o(f_valC_o), .f_valP_o(f_valP_o), .f_stat_o(f_stat_o),
        .f_wait_o(f_wait_o),
`ifdef FETCH_PERF_CNT_EN
        .perf_inst_o(perf_inst), .perf_wait_o(perf_wait),
`endif
        .f_pc_o(f_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0]  icode, ifun, ra, rb, stat;
        logic [63:0] valc, valp, pred;
    } dec_t;

    typedef struct {
        logic [63:0]  pc;
        logic [79:0]  data;
        logic         err;
        logic [147:0] exp;
    } vec_t;

    localparam logic [79:0] IRM = {64'h0A, 8'hF3, 8'h30};
    localparam logic [79:0] JMP = {8'h00, 64'h100, 8'h70};

    // Hashed instruction memory: every address yields deterministic bytes/err
    function automatic logic [80:0] mem_word(input logic [63:0] a);
        logic [63:0] h1, h2;
        h1 = a * 64'h9E3779B97F4A7C15;
        h1 = h1 ^ (h1 >> 29);
        h2 = (a + 64'h1234) * 64'hBF58476D1CE4E5B9;
        h2 = h2 ^ (h2 >> 31);
        return {(h2[20:16] == 5'd0), h2[15:0], h1};
    endfunction

    always_comb begin
        if (use_mem) {imem_err_i, imem_data_i} = mem_word(imem_addr_o);
        else         {imem_err_i, imem_data_i} = {drv_err, drv_data};
    end

    // Y86 instruction decode from the ISA rules
    function automatic dec_t decode(input logic [63:0] pc, input logic [79:0] d, input logic e);
        dec_t r;
        logic regs, vc;
        r.icode = e ? 4'h1 : d[7:4];
        r.ifun  = e ? 4'h0 : d[3:0];
        regs = (r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
        vc   = (r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8});
        r.ra = regs ? d[15:12] : 4'hF;
        r.rb = regs ? d[11:8]  : 4'hF;
        r.valc = !vc ? 64'h0 : (regs ? d[79:16] : d[71:8]);
        r.valp = pc + 64'(1 + (regs ? 1 : 0) + (vc ? 8 : 0));
        r.pred = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
        r.stat = e ? 4'h3 : (d[7:4] > 4'hB) ? 4'h4 : (r.icode == 4'h0) ? 4'h2 : 4'h1;
        return r;
    endfunction

    function automatic logic [147:0] pk(input dec_t d);
        return {d.icode, d.ifun, d.ra, d.rb, d.stat, d.valc, d.valp};
    endfunction

    function automatic logic [147:0] act_out();
        return {f_icode_o, f_ifun_o, f_rA_o, f_rB_o, f_stat_o, f_valC_o, f_valP_o};
    endfunction

    localparam logic [147:0] BUBBLE = {4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 64'h0, 64'h0};

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[11];
    logic [63:0] exp_pc, wpc, hpc, a;
    logic        held, waiting;
    logic [80:0] mw;
    dec_t        e;
    int          n_acc, n_wait;

    initial begin
        vecs[0]  = '{pc: 64'h100, data: IRM, err: 1'b0,
                     exp: {4'h3, 4'h0, 4'hF, 4'h3, 4'h1, 64'hA, 64'h10A}};
        vecs[1]  = '{pc: 64'h0, data: {72'h0, 8'hC0}, err: 1'b0,
                     exp: {4'hC, 4'h0, 4'hF, 4'hF, 4'h4, 64'h0, 64'h1}};
        vecs[2]  = '{pc: 64'h10, data: IRM, err: 1'b1,
                     exp: {4'h1, 4'h0, 4'hF, 4'hF, 4'h3, 64'h0, 64'h11}};
        vecs[3]  = '{pc: 64'h20, data: {72'h0, 8'h00}, err: 1'b0,
                     exp: {4'h0, 4'h0, 4'hF, 4'hF, 4'h2, 64'h0, 64'h21}};
        vecs[4]  = '{pc: 64'hFFFF_FFFF_FFFF_FFFF, data: {72'h123456789ABCDEF012, 8'h10}, err: 1'b0,
                     exp: {4'h1, 4'h0, 4'hF, 4'hF, 4'h1, 64'h0, 64'h0}};
        vecs[5]  = '{pc: 64'h20, data: {8'h00, 64'h100, 8'h74}, err: 1'b0,
                     exp: {4'h7, 4'h4, 4'hF, 4'hF, 4'h1, 64'h100, 64'h29}};
        vecs[6]  = '{pc: 64'h40, data: {64'hDEAD, 8'h12, 8'h20}, err: 1'b0,
                     exp: {4'h2, 4'h0, 4'h1, 4'h2, 4'h1, 64'h0, 64'h42}};
        vecs[7]  = '{pc: 64'h50, data: {8'h00, 64'h1122334455667788, 8'h80}, err: 1'b0,
                     exp: {4'h8, 4'h0, 4'hF, 4'hF, 4'h1, 64'h1122334455667788, 64'h59}};
        vecs[8]  = '{pc: 64'h60, data: {64'h0102030405060708, 8'h15, 8'h50}, err: 1'b0,
                     exp: {4'h5, 4'h0, 4'h1, 4'h5, 4'h1, 64'h0102030405060708, 64'h6A}};
        vecs[9]  = '{pc: 64'h70, data: {64'h0, 8'h4F, 8'hB0}, err: 1'b0,
                     exp: {4'hB, 4'h0, 4'h4, 4'hF, 4'h1, 64'h0, 64'h72}};
        vecs[10] = '{pc: 64'h80, data: {72'h0, 8'hD3}, err: 1'b0,
                     exp: {4'hD, 4'h3, 4'hF, 4'hF, 4'h4, 64'h0, 64'h81}};

        rstn_i = 1'b0; F_stall_i = 1'b0; M_icode_i = 4'h0; M_cnd_i = 1'b1; M_valA_i = 64'h0;
        W_icode_i = 4'h0; W_valM_i = 64'h0; imem_ready_i = 1'b1;
        use_mem = 1'b0; drv_data = IRM; drv_err = 1'b0;

        // Reset and first irmovq
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_req", 192'(imem_req_o), 192'(0));
        chk("reset_wait", 192'(f_wait_o), 192'(0));
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("first_addr", 192'(imem_addr_o), 192'(0));
        chk("first_fields", 192'(act_out()), 192'(pk(decode(64'h0, IRM, 1'b0))));
        chk("first_wait", 192'(f_wait_o), 192'(0));
        tick();

        // Three wait cycles, redirect ignored while waiting
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin W_icode_i = 4'h9; W_valM_i = 64'h999; end
            else W_icode_i = 4'h0;
            @(negedge clk_i);
            chk("wait_flag", 192'(f_wait_o), 192'(1));
            chk("wait_addr", 192'(imem_addr_o), 192'(64'hA));
            chk("wait_bubble", 192'(act_out()), 192'(BUBBLE));
            tick();
        end
        W_icode_i = 4'h0; imem_ready_i = 1'b1;
        @(negedge clk_i);
        chk("wait_done", 192'({f_wait_o, f_pc_o}), 192'({1'b0, 64'hA}));
        chk("wait_fields", 192'(act_out()), 192'(pk(decode(64'hA, IRM, 1'b0))));
        tick();

        // Stall two cycles on ready, memory data changes under the hold
        F_stall_i = 1'b1;
        @(negedge clk_i);
        chk("stall_addr", 192'({imem_req_o, imem_addr_o}), 192'({1'b1, 64'h14}));
        tick();
        drv_data = 80'h0;
        @(negedge clk_i);
        chk("hold_req", 192'(imem_req_o), 192'(0));
        chk("hold_fields", 192'(act_out()), 192'(pk(decode(64'h14, IRM, 1'b0))));
        tick();
        F_stall_i = 1'b0;
        @(negedge clk_i);
        chk("hold_rel", 192'({imem_req_o, f_pc_o}), 192'({1'b0, 64'h14}));
        chk("hold_rel_fields", 192'(act_out()), 192'(pk(decode(64'h14, IRM, 1'b0))));
        tick();

        // jXX prediction, mispredict and ret recovery
        drv_data = JMP;
        @(negedge clk_i);
        chk("after_hold_addr", 192'({imem_req_o, imem_addr_o}), 192'({1'b1, 64'h1E}));
        chk("jmp_fields", 192'(act_out()), 192'(pk(decode(64'h1E, JMP, 1'b0))));
        tick();
        drv_data = IRM;
        @(negedge clk_i);
        chk("jmp_target", 192'(imem_addr_o), 192'(64'h100));
        tick();
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h29;
        @(negedge clk_i);
        chk("mispredict", 192'(imem_addr_o), 192'(64'h29));
        tick();
        M_icode_i = 4'h0; W_icode_i = 4'h9; W_valM_i = 64'h40;
        @(negedge clk_i);
        chk("ret", 192'(imem_addr_o), 192'(64'h40));
        tick();
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h55;
        @(negedge clk_i);
        chk("redirect_prio", 192'(imem_addr_o), 192'(64'h55));
        tick();
        M_cnd_i = 1'b1;
        @(negedge clk_i);
        chk("taken_no_redirect", 192'(imem_addr_o), 192'(64'h40));
        tick();
        W_icode_i = 4'h0;

        // Vector table: PC forced via mispredict path, one instruction each
        for (int i = 0; i < 11; i++) begin
            M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = vecs[i].pc;
            drv_data = vecs[i].data; drv_err = vecs[i].err;
            @(negedge clk_i);
            chk($sformatf("vec%0d_addr", i), 192'(imem_addr_o), 192'(vecs[i].pc));
            chk($sformatf("vec%0d_fields", i), 192'(act_out()), 192'(vecs[i].exp));
            tick();
        end
        M_icode_i = 4'h0; M_cnd_i = 1'b1; drv_err = 1'b0; drv_data = IRM;

        // Reset in the middle of a wait
        imem_ready_i = 1'b0;
        @(negedge clk_i);
        chk("pre_reset_wait", 192'(f_wait_o), 192'(1));
        #1 rstn_i = 1'b0;
        #1 chk("reset_drop_req", 192'(imem_req_o), 192'(0));
        tick();
        rstn_i = 1'b1;

        // Randomized run against the transaction model
        use_mem = 1'b1;
        exp_pc = 64'h0; held = 1'b0; waiting = 1'b0; n_acc = 0; n_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            imem_ready_i = ($urandom_range(0, 3) != 0);
            F_stall_i    = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = {$urandom, $urandom};
            end else begin
                M_icode_i = 4'($urandom_range(0, 15)); M_cnd_i = 1'b1; M_valA_i = {$urandom, $urandom};
            end
            W_icode_i = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'($urandom_range(0, 8));
            W_valM_i  = {$urandom, $urandom};
            if (i == 0) begin
                M_icode_i = 4'h0; W_icode_i = 4'h0; imem_ready_i = 1'b1;
            end
            @(negedge clk_i);
            if (i == 0) chk("post_reset_pc", 192'(imem_addr_o), 192'(64'h0));
            if (held) begin
                mw = mem_word(hpc);
                e = decode(hpc, mw[79:0], mw[80]);
                chk("rnd_hold_req", 192'({imem_req_o, f_wait_o}), 192'(0));
                chk("rnd_hold_out", 192'({act_out(), f_pc_o}), 192'({pk(e), hpc}));
                if (!F_stall_i) begin held = 1'b0; exp_pc = e.pred; n_acc++; end
            end else begin
                if (waiting) a = wpc;
                else if (M_icode_i == 4'h7 && !M_cnd_i) a = M_valA_i;
                else if (W_icode_i == 4'h9) a = W_valM_i;
                else a = exp_pc;
                chk("rnd_req", 192'({imem_req_o, imem_addr_o}), 192'({1'b1, a}));
                if (!imem_ready_i) begin
                    chk("rnd_bubble", 192'({f_wait_o, act_out()}), 192'({1'b1, BUBBLE}));
                    waiting = 1'b1; wpc = a; n_wait++;
                end else begin
                    mw = mem_word(a);
                    e = decode(a, mw[79:0], mw[80]);
                    chk("rnd_out", 192'({f_wait_o, act_out(), f_pc_o}), 192'({1'b0, pk(e), a}));
                    waiting = 1'b0;
                    if (F_stall_i) begin held = 1'b1; hpc = a; end
                    else begin exp_pc = e.pred; n_acc++; end
                end
            end
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_inst", 192'(perf_inst), 192'(32'(n_acc)));
        chk("perf_wait", 192'(perf_wait), 192'(32'(n_wait)));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Y86-64 pipeline fetch stage. It sits directly upstream of the decode pipeline register and drives its f_* inputs.
- Holds the F pipeline register (predicted PC) and selects the fetch PC, including mispredict and ret recovery.
- Runs a request/ready handshake with instruction memory.
- Splits the 10-byte instruction window into icode, ifun, rA, rB and valC, and computes valP, the next predicted PC and the instruction status.

Parameters:
RESET_PC, 64'h0, predicted-PC value loaded at reset

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous active-low
F_stall_i  in  1  hold current instruction; do not advance predPC
M_icode_i  in  4  memory-stage icode
M_cnd_i  in  1  memory-stage branch condition
M_valA_i  in  64  memory-stage valA (fall-through PC of jXX)
W_icode_i  in  4  write-back-stage icode
W_valM_i  in  64  write-back-stage valM (ret target)
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  64  fetch byte address
imem_ready_i  in  1  imem_data_i/imem_err_i valid this cycle
imem_data_i  in  80  10 instruction bytes, little-endian, byte0 = [7:0]
imem_err_i  in  1  address error
f_icode_o  out  4  to decode register
f_ifun_o  out  4  to decode register
f_rA_o  out  4  to decode register
f_rB_o  out  4  to decode register
f_valC_o  out  64  to decode register
f_valP_o  out  64  to decode register
f_stat_o  out  4  to decode register
f_wait_o  out  1  fetch not complete; pipeline control stalls F and bubbles D
f_pc_o  out  64  PC of the instruction presented

Behaviour:
- Reset (async, rstn_i low):
  - predPC = RESET_PC; state = FETCH; addr_q = 0; buffer cleared.
  - Combinational outputs follow the FETCH rules from the first cycle after reset.
- PC select, combinational, in priority order:
  - M_icode_i==IJXX && !M_cnd_i -> M_valA_i
  - W_icode_i==IRET -> W_valM_i
  - otherwise predPC
- State FETCH:
  - imem_req_o=1; imem_addr_o = selected PC; addr_q <= selected PC.
  - If imem_ready_i is high, the instruction is valid the same cycle:
    - F_stall_i=0: predPC <= f_predPC; stay in FETCH.
    - F_stall_i=1: capture data, error flag and PC into the buffer; go to HOLD.
  - If imem_ready_i is low: go to WAIT.
- State WAIT:
  - imem_req_o=1; imem_addr_o = addr_q, stable until ready.
  - Redirect inputs are ignored; pipeline control stalls globally while f_wait_o=1.
  - On ready: same F_stall_i split as FETCH (advance and go to FETCH, or capture and go to HOLD).
- State HOLD:
  - imem_req_o=0; outputs are driven from the buffer.
  - When F_stall_i=0: predPC <= buffered f_predPC; go to FETCH.
- f_wait_o = imem_req_o && !imem_ready_i.
  - While f_wait_o=1, outputs are a bubble: icode INOP, ifun 0, rA/rB RNONE, valC 0, valP 0, stat SAOK.
- Field split:
  - icode = byte0[7:4]; ifun = byte0[3:0].
  - If imem error: icode forced INOP, ifun forced 0.
  - need_regids for icode in {2,3,4,5,6,A,B}; need_valC for icode in {3,4,5,7,8}.
  - rA = byte1[7:4] and rB = byte1[3:0] if need_regids, else RNONE.
  - valC = bytes 2..9 if need_regids, else bytes 1..8; 0 if !need_valC.
  - valP = pc + 1 + need_regids + 8*need_valC, modulo 2^64 (wrap allowed).
- f_predPC = valC for IJXX/ICALL; valP otherwise.
- stat priority: imem_err -> SADR; icode > 4'hB -> SINS; icode==IHALT -> SHLT; else SAOK.
- Fetch continues after SHLT/SADR/SINS; stopping is the pipeline control's job.
- Reset mid-WAIT: request dropped immediately; the next request goes to RESET_PC.

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_inst_o[31:0] and perf_wait_o[31:0], both reset to 0.
  - perf_inst_o counts +1 per instruction accepted (ready or HOLD with F_stall_i=0).
  - perf_wait_o counts +1 per cycle with f_wait_o=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, RESET_PC=0, ready tied 1, data byte0..9 = 30 F3 0A 00.. (irmovq $10,%rbx) -> f_icode 3, rA F, rB 3, valC 10, valP 10, stat SAOK; next imem_addr_o=10.
- ready held low 3 cycles -> f_wait_o=1 for 3 cycles, imem_addr_o stable, bubble outputs; 4th cycle ready -> valid fields, f_wait_o=0.
- F_stall_i=1 for 2 cycles on ready -> HOLD with imem_req_o=0, outputs unchanged; release -> one new request at valP.
- jXX at 0x20 with valC 0x100 -> next addr 0x100; later M_icode=7, M_cnd=0, M_valA=0x29 -> imem_addr_o=0x29 that cycle; W_icode=9, W_valM=0x40 -> addr 0x40.
- byte0=0xC0 -> stat SINS; imem_err_i=1 -> icode 1, stat SADR; byte0=0x00 -> stat SHLT; valP wraps at PC 64'hFFFF_FFFF_FFFF_FFFF with a 1-byte instruction -> 0.
- FETCH_PERF_CNT_EN defined, 5 instructions with 2 wait cycles -> perf_inst_o=5, perf_wait_o=2.
